// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One outstanding request at a time: req/addr/ready form the request handshake,
// valid/data carry the response one or more cycles after acceptance.
interface fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] data;

    modport master (
        output req,
        output addr,
        input  ready,
        input  valid,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output valid,
        output data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, keeps a single request in flight to a variable-latency memory,
// parks a returned instruction in a buffer while the hazard unit stalls,
// and flushes/redirects on a taken branch resolved in ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pcWrite_i,
    input  logic              IFIDWrite_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branchTarget_i,
    fetch_stage_if.master     imem,
    output logic [ADDR_W-1:0] IFIDpc_o,
    output logic [DATA_W-1:0] IFIDinstr_o,
    output logic              IFIDvalid_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [DATA_W-1:0] buffer;
    logic [DATA_W-1:0] next_buffer;
    logic              deliver;
    logic [DATA_W-1:0] deliver_instr;
    logic              advance;
    logic              accept;

    // Both hazard controls must allow progress; either one alone is a stall.
    assign advance  = pcWrite_i && IFIDWrite_i;
    assign pc_plus4 = pc + ADDR_W'(4);

    // Requests only go out from REQ, never while reset is held.
    assign imem.req  = (state == S_REQ) && !rst_i;
    assign imem.addr = pc;
    assign accept    = imem.req && imem.ready;

    // State, PC and stall buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_REQ;
            pc     <= RESET_PC[ADDR_W-1:0];
            buffer <= '0;
        end else begin
            state  <= next_state;
            pc     <= next_pc;
            buffer <= next_buffer;
        end
    end

    // Next-state, PC redirect/increment, buffering and instruction delivery.
    always_comb begin
        next_state    = state;
        next_pc       = pc;
        next_buffer   = buffer;
        deliver       = 1'b0;
        deliver_instr = '0;
        unique case (state)
            S_REQ: begin
                if (branch_i) begin
                    next_pc = branchTarget_i;
                    if (accept) begin
                        next_state = S_DISCARD;
                    end
                end else if (accept) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.valid) begin
                    if (branch_i) begin
                        next_pc    = branchTarget_i;
                        next_state = S_REQ;
                    end else if (advance) begin
                        deliver       = 1'b1;
                        deliver_instr = imem.data;
                        next_pc       = pc_plus4;
                        next_state    = S_REQ;
                    end else begin
                        next_buffer = imem.data;
                        next_state  = S_HOLD;
                    end
                end else if (branch_i) begin
                    next_pc    = branchTarget_i;
                    next_state = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (branch_i) begin
                    next_pc    = branchTarget_i;
                    next_state = S_REQ;
                end else if (advance) begin
                    deliver       = 1'b1;
                    deliver_instr = buffer;
                    next_pc       = pc_plus4;
                    next_state    = S_REQ;
                end
            end
            S_DISCARD: begin
                if (branch_i) begin
                    next_pc = branchTarget_i;
                end
                if (imem.valid) begin
                    next_state = S_REQ;
                end
            end
            default: begin
                next_state = S_REQ;
            end
        endcase
    end

    // IF/ID register: flush beats stall, stall beats load, otherwise a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            IFIDpc_o    <= '0;
            IFIDinstr_o <= '0;
            IFIDvalid_o <= 1'b0;
        end else if (branch_i) begin
            IFIDinstr_o <= '0;
            IFIDvalid_o <= 1'b0;
        end else if (IFIDWrite_i) begin
            if (deliver) begin
                IFIDpc_o    <= pc_plus4;
                IFIDinstr_o <= deliver_instr;
                IFIDvalid_o <= 1'b1;
            end else begin
                IFIDinstr_o <= '0;
                IFIDvalid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: free-run, hazard stall, branch flush,
// flush under stall, reset mid-transaction, and PC wrap from a high RESET_PC.
// The memory model answers mem[A] = A + 0x100 with a programmable latency.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic        pc_write = 1'b1;
    logic        ifid_write = 1'b1;
    logic        branch = 1'b0;
    logic [31:0] target = 32'h0;
    logic        ready = 1'b1;
    int          lat = 0;

    logic [31:0] ifid_pc, ifid_pc2;
    logic [31:0] ifid_instr, ifid_instr2;
    logic        ifid_valid, ifid_valid2;

    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_paddr = 32'h0;

    logic        mem2_valid = 1'b0;
    logic [31:0] mem2_data = 32'h0;

    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem1 ();
    fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem2 ();

    assign imem1.ready = ready;
    assign imem1.valid = mem_valid;
    assign imem1.data  = mem_data;
    assign imem2.ready = 1'b1;
    assign imem2.valid = mem2_valid;
    assign imem2.data  = mem2_data;

    fetch_stage #(.RESET_PC(32'h0), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pcWrite_i      (pc_write),
        .IFIDWrite_i    (ifid_write),
        .branch_i       (branch),
        .branchTarget_i (target),
        .imem           (imem1),
        .IFIDpc_o       (ifid_pc),
        .IFIDinstr_o    (ifid_instr),
        .IFIDvalid_o    (ifid_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(32), .DATA_W(32)) dut_wrap (
        .clk_i          (clk),
        .rst_i          (rst2),
        .pcWrite_i      (1'b1),
        .IFIDWrite_i    (1'b1),
        .branch_i       (1'b0),
        .branchTarget_i (32'h0),
        .imem           (imem2),
        .IFIDpc_o       (ifid_pc2),
        .IFIDinstr_o    (ifid_instr2),
        .IFIDvalid_o    (ifid_valid2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory for the main DUT: latency 0 answers in the cycle after accept.
    always @(posedge clk) begin
        mem_valid <= 1'b0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                mem_valid <= 1'b1;
                mem_data  <= mem_paddr + 32'h100;
                mem_pend  <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
        if (imem1.req && imem1.ready) begin
            if (lat == 0) begin
                mem_valid <= 1'b1;
                mem_data  <= imem1.addr + 32'h100;
            end else begin
                mem_pend  <= 1'b1;
                mem_cnt   <= lat - 1;
                mem_paddr <= imem1.addr;
            end
        end
    end

    // Zero-wait memory for the wrap-around DUT.
    always @(posedge clk) begin
        mem2_valid <= imem2.req;
        if (imem2.req) begin
            mem2_data <= imem2.addr + 32'h100;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check_output("rst_req", {31'b0, imem1.req}, 32'h0);
        check_output("rst_addr", imem1.addr, 32'h0);
        check_output("rst_ifid_pc", ifid_pc, 32'h0);
        check_output("rst_ifid_instr", ifid_instr, 32'h0);
        check_output("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] free-run from reset");
        do_reset();
        step();
        check_output("fr_e1_valid", {31'b0, ifid_valid}, 32'h0);
        check_output("fr_e1_req", {31'b0, imem1.req}, 32'h0);
        step();
        check_output("fr_i0_pc", ifid_pc, 32'h4);
        check_output("fr_i0_instr", ifid_instr, 32'h100);
        check_output("fr_i0_valid", {31'b0, ifid_valid}, 32'h1);
        check_output("fr_i0_addr", imem1.addr, 32'h4);
        step();
        check_output("fr_bub_valid", {31'b0, ifid_valid}, 32'h0);
        check_output("fr_bub_instr", ifid_instr, 32'h0);
        check_output("fr_bub_pc", ifid_pc, 32'h4);
        step();
        check_output("fr_i1_pc", ifid_pc, 32'h8);
        check_output("fr_i1_instr", ifid_instr, 32'h104);
        step();
        check_output("fr_bub2_valid", {31'b0, ifid_valid}, 32'h0);
        step();
        check_output("fr_i2_pc", ifid_pc, 32'hC);
        check_output("fr_i2_instr", ifid_instr, 32'h108);
        check_output("fr_i2_valid", {31'b0, ifid_valid}, 32'h1);

        $display("[TB] hazard stall while response for pc 8 returns");
        do_reset();
        step();
        step();
        step();
        step();
        check_output("st_pre_instr", ifid_instr, 32'h104);
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        step();
        check_output("st_e5_req", {31'b0, imem1.req}, 32'h0);
        check_output("st_e5_instr", ifid_instr, 32'h104);
        step();
        check_output("st_e6_instr", ifid_instr, 32'h104);
        check_output("st_e6_addr", imem1.addr, 32'h8);
        step();
        check_output("st_hold_instr", ifid_instr, 32'h104);
        check_output("st_hold_valid", {31'b0, ifid_valid}, 32'h1);
        check_output("st_hold_req", {31'b0, imem1.req}, 32'h0);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        step();
        check_output("st_rel_pc", ifid_pc, 32'hC);
        check_output("st_rel_instr", ifid_instr, 32'h108);
        check_output("st_rel_valid", {31'b0, ifid_valid}, 32'h1);
        check_output("st_rel_addr", imem1.addr, 32'hC);

        $display("[TB] branch while waiting on a slow response");
        lat = 1;
        do_reset();
        step();
        branch = 1'b1;
        target = 32'h40;
        step();
        branch = 1'b0;
        check_output("br_flush_valid", {31'b0, ifid_valid}, 32'h0);
        check_output("br_flush_instr", ifid_instr, 32'h0);
        check_output("br_disc_req", {31'b0, imem1.req}, 32'h0);
        check_output("br_addr", imem1.addr, 32'h40);
        step();
        check_output("br_reissue_req", {31'b0, imem1.req}, 32'h1);
        check_output("br_reissue_addr", imem1.addr, 32'h40);
        check_output("br_drop_valid", {31'b0, ifid_valid}, 32'h0);
        step();
        step();
        check_output("br_wait_valid", {31'b0, ifid_valid}, 32'h0);
        step();
        check_output("br_tgt_pc", ifid_pc, 32'h44);
        check_output("br_tgt_instr", ifid_instr, 32'h140);
        check_output("br_tgt_valid", {31'b0, ifid_valid}, 32'h1);

        $display("[TB] branch together with IF/ID stall");
        branch     = 1'b1;
        target     = 32'h80;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        step();
        branch     = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        check_output("bs_valid", {31'b0, ifid_valid}, 32'h0);
        check_output("bs_instr", ifid_instr, 32'h0);
        check_output("bs_pc_kept", ifid_pc, 32'h44);
        check_output("bs_addr", imem1.addr, 32'h80);
        step();
        check_output("bs_disc_req", {31'b0, imem1.req}, 32'h0);
        step();
        check_output("bs_reissue_req", {31'b0, imem1.req}, 32'h1);
        check_output("bs_reissue_addr", imem1.addr, 32'h80);
        step();
        step();
        step();
        check_output("bs_tgt_pc", ifid_pc, 32'h84);
        check_output("bs_tgt_instr", ifid_instr, 32'h180);

        $display("[TB] reset during WAIT, stale response afterwards");
        lat = 3;
        do_reset();
        step();
        check_output("rw_wait_req", {31'b0, imem1.req}, 32'h0);
        rst   = 1'b1;
        ready = 1'b0;
        step();
        check_output("rw_rst_req", {31'b0, imem1.req}, 32'h0);
        check_output("rw_rst_valid", {31'b0, ifid_valid}, 32'h0);
        rst = 1'b0;
        step();
        check_output("rw_e3_req", {31'b0, imem1.req}, 32'h1);
        check_output("rw_e3_addr", imem1.addr, 32'h0);
        step();
        check_output("rw_e4_valid", {31'b0, ifid_valid}, 32'h0);
        step();
        check_output("rw_e5_valid", {31'b0, ifid_valid}, 32'h0);
        check_output("rw_e5_instr", ifid_instr, 32'h0);
        check_output("rw_e5_pc", ifid_pc, 32'h0);
        check_output("rw_e5_req", {31'b0, imem1.req}, 32'h1);
        check_output("rw_e5_addr", imem1.addr, 32'h0);
        ready = 1'b1;
        lat   = 0;
        step();
        step();
        check_output("rw_i0_pc", ifid_pc, 32'h4);
        check_output("rw_i0_instr", ifid_instr, 32'h100);
        check_output("rw_i0_valid", {31'b0, ifid_valid}, 32'h1);

        $display("[TB] PC wrap from RESET_PC 0xFFFFFFFC");
        rst = 1'b1;
        check_output("wr_rst_req", {31'b0, imem2.req}, 32'h0);
        check_output("wr_rst_addr", imem2.addr, 32'hFFFF_FFFC);
        check_output("wr_rst_valid", {31'b0, ifid_valid2}, 32'h0);
        rst2 = 1'b0;
        step();
        step();
        check_output("wr_i0_pc", ifid_pc2, 32'h0);
        check_output("wr_i0_instr", ifid_instr2, 32'hFC);
        check_output("wr_i0_valid", {31'b0, ifid_valid2}, 32'h1);
        check_output("wr_next_addr", imem2.addr, 32'h0);
        step();
        step();
        check_output("wr_i1_pc", ifid_pc2, 32'h4);
        check_output("wr_i1_instr", ifid_instr2, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
